// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The optional UART_RX_MAJORITY_EN build uses maj3() for 2-of-3 bit voting.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both stages reset to 1,
// which is the idle level of the UART line.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with start-bit glitch reject and framing check.
// Define UART_RX_MAJORITY_EN to vote each bit sample over three os_ticks.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit, re-checking the line is still low
// DATA  | sampling 8 data bits LSB first, one per bit time
// STOP  | sampling the stop bit; publishes the byte or flags a framing error
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       os_tick,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          rxs;
    logic          rxs_d_q;
    logic          rxs_d_d;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bit_cnt_q;
    logic [2:0]    bit_cnt_d;
    logic [7:0]    shreg_q;
    logic [7:0]    shreg_d;
    logic [7:0]    rx_data_q;
    logic [7:0]    rx_data_d;
    logic          rx_valid_q;
    logic          rx_valid_d;
    logic          frame_err_q;
    logic          frame_err_d;
    logic          sample;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rxs)
    );

    always_comb begin
        rxs_d_d = rxs;
    end

`ifdef UART_RX_MAJORITY_EN
    // Holds rxs from the two previous os_ticks; the counter advances on every
    // tick, so at count N these are the values seen at N-1 and N-2.
    logic [1:0] maj_q;
    logic [1:0] maj_d;

    always_comb begin
        maj_d = maj_q;
        if (os_tick) begin
            maj_d = {maj_q[0], rxs};
        end
        sample = maj3(maj_q[1], maj_q[0], rxs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= maj_d;
        end
    end
`else
    always_comb begin
        sample = rxs;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Edge, not level: a line stuck low cannot start a new frame.
                if (rxs_d_q && !rxs) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (os_tick) begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d   = '0;
                        state_d = sample ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            DATA: begin
                if (os_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        shreg_d   = {sample, shreg_q[7:1]};
                        cnt_d     = '0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            STOP: begin
                if (os_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        if (sample) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_d_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxs_d_q     <= rxs_d_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed scenarios plus random frames,
// os_tick every 4 clk, OVERSAMPLE 16 (one bit = 16 ticks = 64 clk).
module tb_uart_receiver;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       os_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         t_start;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    bit         prev_v = 1'b0;
    bit         prev_e = 1'b0;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .os_tick   (os_tick),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            os_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the caller 1 time unit after the n-th os_tick edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!os_tick);
        end
        #1;
    endtask

    // Reference: a frame with stop=1 delivers recv_byte; stop=0 flags an error
    // and leaves the previously delivered byte on rx_data.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int glitch_bit,
                              input logic [7:0] recv_byte, input bit chk_busy);
        exp_t e;
        e.is_err  = !stop;
        e.data    = stop ? recv_byte : last_good;
        e.t_start = cyc;
        if (stop) last_good = recv_byte;
        exp_q.push_back(e);

        rx_in = 1'b0;
        wait_ticks(1);
        if (chk_busy) check("busy_start", busy, 1);
        wait_ticks(OS - 1);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            if (glitch_bit == i) begin
                wait_ticks(OS / 2 - 1);
                rx_in = 1'b1;
                wait_ticks(1);
                rx_in = b[i];
                wait_ticks(OS / 2);
            end else begin
                wait_ticks(OS);
            end
            if (chk_busy) check("busy_data", busy, 1);
        end
        rx_in = stop;
        wait_ticks(4);
        if (chk_busy) check("busy_stop", busy, 1);
        wait_ticks(OS - 4);
    endtask

    always @(negedge clk) begin
        if (rx_valid && frame_err) begin
            checks++;
            errors++;
            $display("FAIL exclusive: rx_valid=%b frame_err=%b both high", rx_valid, frame_err);
        end
        if ((rx_valid && prev_v) || (frame_err && prev_e)) begin
            checks++;
            errors++;
            $display("FAIL pulse_width: output high for more than one cycle");
        end
        if (rx_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: rx_valid=%b frame_err=%b rx_data=0x%0h, none expected",
                         rx_valid, frame_err, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind_err", frame_err, mon_e.is_err);
                check("pulse_kind_valid", rx_valid, !mon_e.is_err);
                check("rx_data", rx_data, mon_e.data);
                check("latency_window", ((cyc - mon_e.t_start) >= 600) && ((cyc - mon_e.t_start) <= 620), 1);
            end
        end
        prev_v = rx_valid;
        prev_e = frame_err;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        logic [7:0] b;
        bit         stop;
        int         gap;
        int         n;

        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Clean frame with busy tracking
        send_frame(8'hA5, 1'b1, -1, 8'hA5, 1'b1);
        wait_ticks(4);
        check("busy_after_frame", busy, 0);
        check("rx_data_hold_a5", rx_data, 8'hA5);

        // Short low pulse rejected in START
        rx_in = 1'b0;
        wait_ticks(4);
        rx_in = 1'b1;
        wait_ticks(20);
        check("busy_after_glitch", busy, 0);

        // Framing error, line then held low: must not retrigger
        send_frame(8'h3C, 1'b0, -1, 8'h00, 1'b0);
        wait_ticks(40);
        check("busy_line_low", busy, 0);
        check("rx_data_kept_after_ferr", rx_data, 8'hA5);
        rx_in = 1'b1;
        wait_ticks(4);
        send_frame(8'h55, 1'b1, -1, 8'h55, 1'b0);

        // Back-to-back, zero idle gap
        send_frame(8'h00, 1'b1, -1, 8'h00, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 8'hFF, 1'b0);
        wait_ticks(4);

        // Reset in the middle of bit 3 of 0x5A
        b = 8'h5A;
        rx_in = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            rx_in = b[i];
            wait_ticks(OS);
        end
        rx_in = b[3];
        wait_ticks(OS / 2);
        rst_n = 1'b0;
        #2;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_busy", busy, 0);
        check("midreset_rx_valid", rx_valid, 0);
        rx_in = 1'b1;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ticks(4);
        check("post_reset_rx_data", rx_data, 8'h00);
        check("post_reset_busy", busy, 0);
        send_frame(8'h81, 1'b1, -1, 8'h81, 1'b0);
        wait_ticks(2);

        // One-tick high glitch at the sample point of data bit 2
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 1'b1, 2, 8'h00, 1'b0);
`else
        send_frame(8'h00, 1'b1, 2, 8'h04, 1'b0);
`endif
        wait_ticks(2);

        // Random frames, mostly good, occasional framing errors
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            gap  = $urandom_range(0, 3);
            send_frame(b, stop, -1, b, 1'b0);
            if (!stop) begin
                rx_in = 1'b1;
                gap = gap + 1;
            end
            if (gap > 0) wait_ticks(gap);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("queue_drained", exp_q.size(), 0);
        wait_ticks(4);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
